// File: rtl/tetris_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_vga_pkg
// Summary  : Shared geometry defaults, palette and pipeline types for the
//            Tetris playfield pixel renderer.
// Revision : 1.0
// ============================================================================
package tetris_vga_pkg;

    localparam int DEF_X0     = 220;
    localparam int DEF_Y0     = 40;
    localparam int DEF_CELL   = 20;
    localparam int DEF_COLS   = 10;
    localparam int DEF_ROWS   = 20;
    localparam int DEF_BORDER = 4;

    localparam int PIX_LAT = 3;
    localparam int COORD_W = 11;
    localparam int CX_W    = 4;
    localparam int CY_W    = 5;
    localparam int PIX_W   = 5;
    localparam int ADDR_W  = 8;

    localparam logic [COORD_W-1:0] LAST_ACTIVE_ROW = 11'd479;

    localparam logic [7:0] BLANK_COLOR  = 8'h00;
    localparam logic [7:0] GRID_COLOR   = 8'h49;
    localparam logic [7:0] BORDER_COLOR = 8'hFF;

    localparam logic [7:0] PAL_0 = 8'h00;
    localparam logic [7:0] PAL_1 = 8'h1F;
    localparam logic [7:0] PAL_2 = 8'hFC;
    localparam logic [7:0] PAL_3 = 8'h83;
    localparam logic [7:0] PAL_4 = 8'h1C;
    localparam logic [7:0] PAL_5 = 8'hE0;
    localparam logic [7:0] PAL_6 = 8'h03;
    localparam logic [7:0] PAL_7 = 8'hF0;

    // Per-pixel decisions carried from the address stage to the colour stage.
    typedef struct packed {
        logic       ready;
        logic       in_board;
        logic       grid;
        logic       border;
        logic       hit;
        logic [2:0] piece_color;
    } pix_ctl_t;

    function automatic logic [7:0] palette_rgb(input logic [2:0] idx);
        logic [7:0] c;
        c = PAL_0;
        case (idx)
            3'd0: c = PAL_0;
            3'd1: c = PAL_1;
            3'd2: c = PAL_2;
            3'd3: c = PAL_3;
            3'd4: c = PAL_4;
            3'd5: c = PAL_5;
            3'd6: c = PAL_6;
            3'd7: c = PAL_7;
            default: c = PAL_0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tetris_cell_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tetris_cell_tracker
// Summary  : Incremental pixel-to-cell mapping (px/py offsets, cell_x/cell_y)
//            and in-board flag, registered on the first pipeline stage.
// Revision : 1.0
// ============================================================================
module tetris_cell_tracker
    import tetris_vga_pkg::*;
#(
    parameter int X0   = DEF_X0,
    parameter int Y0   = DEF_Y0,
    parameter int CELL = DEF_CELL,
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] col_addr,
    input  logic [COORD_W-1:0] row_addr,
    input  logic               ready,
    input  logic               ready_prev,
    output logic [CX_W-1:0]    cell_x,
    output logic [CY_W-1:0]    cell_y,
    output logic [PIX_W-1:0]   px,
    output logic [PIX_W-1:0]   py,
    output logic               in_board
);

    localparam logic [COORD_W-1:0] X_START  = COORD_W'(X0);
    localparam logic [COORD_W-1:0] X_END    = COORD_W'(X0 + CELL * COLS);
    localparam logic [COORD_W-1:0] Y_START  = COORD_W'(Y0);
    localparam logic [COORD_W-1:0] Y_END    = COORD_W'(Y0 + CELL * ROWS);
    localparam logic [PIX_W-1:0]   PIX_LAST = PIX_W'(CELL - 1);

    logic [CX_W-1:0]  cell_x_q, cell_x_d;
    logic [CY_W-1:0]  cell_y_q, cell_y_d;
    logic [PIX_W-1:0] px_q, px_d;
    logic [PIX_W-1:0] py_q, py_d;
    logic             in_board_q, in_board_d;

    always_comb begin
        cell_x_d   = cell_x_q;
        px_d       = px_q;
        cell_y_d   = cell_y_q;
        py_d       = py_q;
        in_board_d = ready
                     && (col_addr >= X_START) && (col_addr < X_END)
                     && (row_addr >= Y_START) && (row_addr < Y_END);

        if (ready) begin
            if (col_addr == X_START) begin
                cell_x_d = '0;
                px_d     = '0;
            end else if ((col_addr > X_START) && (col_addr < X_END)) begin
                if (px_q == PIX_LAST) begin
                    px_d     = '0;
                    cell_x_d = cell_x_q + 1'b1;
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
        end

        // Rows advance once per line, on the first active pixel of the line.
        if (ready && !ready_prev) begin
            if (row_addr == Y_START) begin
                cell_y_d = '0;
                py_d     = '0;
            end else if ((row_addr > Y_START) && (row_addr < Y_END)) begin
                if (py_q == PIX_LAST) begin
                    py_d     = '0;
                    cell_y_d = cell_y_q + 1'b1;
                end else begin
                    py_d = py_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_x_q   <= '0;
            cell_y_q   <= '0;
            px_q       <= '0;
            py_q       <= '0;
            in_board_q <= 1'b0;
        end else begin
            cell_x_q   <= cell_x_d;
            cell_y_q   <= cell_y_d;
            px_q       <= px_d;
            py_q       <= py_d;
            in_board_q <= in_board_d;
        end
    end

    assign cell_x   = cell_x_q;
    assign cell_y   = cell_y_q;
    assign px       = px_q;
    assign py       = py_q;
    assign in_board = in_board_q;

endmodule
`default_nettype wire

// File: rtl/tetris_board_render.sv
`default_nettype none
// ============================================================================
// Module   : tetris_board_render
// Summary  : Three-stage pixel colour pipeline: maps VGA pixels onto the
//            Tetris playfield, reads board RAM, overlays the falling piece.
// Revision : 1.0
// ============================================================================
module tetris_board_render
    import tetris_vga_pkg::*;
#(
    parameter int X0     = DEF_X0,
    parameter int Y0     = DEF_Y0,
    parameter int CELL   = DEF_CELL,
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int BORDER = DEF_BORDER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] col_addr_sig,
    input  logic [10:0] row_addr_sig,
    input  logic        ready_sig,
    input  logic        hsync_i,
    input  logic        vsync_i,
    output logic [7:0]  board_addr,
    input  logic [2:0]  board_data,
    input  logic [4:0]  piece_x,
    input  logic [5:0]  piece_y,
    input  logic [15:0] piece_mask,
    input  logic [2:0]  piece_color,
    output logic [7:0]  rgb,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_tick
);

    localparam logic [COORD_W-1:0] BX_LO = COORD_W'(X0 - BORDER);
    localparam logic [COORD_W-1:0] BX_HI = COORD_W'(X0 + CELL * COLS + BORDER);
    localparam logic [COORD_W-1:0] BY_LO = COORD_W'(Y0 - BORDER);
    localparam logic [COORD_W-1:0] BY_HI = COORD_W'(Y0 + CELL * ROWS + BORDER);

    // Stage 1
    logic               ready_s1_q, ready_s1_d;
    logic               border_s1_q, border_s1_d;
    logic [COORD_W-1:0] row_s1_q, row_s1_d;
    logic [PIX_LAT-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIX_LAT-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIX_LAT-1:0] tick_pipe_q, tick_pipe_d;
    logic               w_frame_end;

    logic [CX_W-1:0]    w_cell_x;
    logic [CY_W-1:0]    w_cell_y;
    logic [PIX_W-1:0]   w_px;
    logic [PIX_W-1:0]   w_py;
    logic               w_in_board;

    // Stage 2
    pix_ctl_t           ctl_s2_q, ctl_s2_d;
    logic [ADDR_W-1:0]  board_addr_q, board_addr_d;
    logic [6:0]         w_dx;
    logic [6:0]         w_dy;
    logic               w_hit;

    // Stage 3
    logic [7:0]         rgb_q, rgb_d;

    tetris_cell_tracker #(
        .X0   (X0),
        .Y0   (Y0),
        .CELL (CELL),
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cell_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_addr   (col_addr_sig),
        .row_addr   (row_addr_sig),
        .ready      (ready_sig),
        .ready_prev (ready_s1_q),
        .cell_x     (w_cell_x),
        .cell_y     (w_cell_y),
        .px         (w_px),
        .py         (w_py),
        .in_board   (w_in_board)
    );

    always_comb begin
        ready_s1_d  = ready_sig;
        row_s1_d    = row_addr_sig;
        border_s1_d = ready_sig
                      && (col_addr_sig >= BX_LO) && (col_addr_sig < BX_HI)
                      && (row_addr_sig >= BY_LO) && (row_addr_sig < BY_HI);
        // Active video just ended and the last active line was the final row.
        w_frame_end = ready_s1_q && !ready_sig && (row_s1_q == LAST_ACTIVE_ROW);
        hs_pipe_d   = {hs_pipe_q[PIX_LAT-2:0], hsync_i};
        vs_pipe_d   = {vs_pipe_q[PIX_LAT-2:0], vsync_i};
        tick_pipe_d = {tick_pipe_q[PIX_LAT-2:0], w_frame_end};
    end

    // Box-relative offsets; 0 <= d <= 3 exactly when the upper five bits are zero.
    always_comb begin
        w_dx  = {3'b000, w_cell_x} - {{2{piece_x[4]}}, piece_x};
        w_dy  = {2'b00, w_cell_y} - {piece_y[5], piece_y};
        w_hit = (w_dx[6:2] == 5'd0) && (w_dy[6:2] == 5'd0)
                && piece_mask[{w_dy[1:0], w_dx[1:0]}];
    end

    always_comb begin
        ctl_s2_d             = '0;
        ctl_s2_d.ready       = ready_s1_q;
        ctl_s2_d.in_board    = w_in_board;
        ctl_s2_d.grid        = (w_px == '0) || (w_py == '0);
        ctl_s2_d.border      = border_s1_q;
        ctl_s2_d.hit         = w_hit;
        ctl_s2_d.piece_color = piece_color;

        board_addr_d = board_addr_q;
        if (w_in_board) begin
            board_addr_d = ADDR_W'(w_cell_y) * ADDR_W'(COLS) + ADDR_W'(w_cell_x);
        end
    end

    always_comb begin
        rgb_d = BLANK_COLOR;
        if (!ctl_s2_q.ready) begin
            rgb_d = BLANK_COLOR;
        end else if (ctl_s2_q.in_board) begin
            if (ctl_s2_q.grid) begin
                rgb_d = GRID_COLOR;
            end else if (ctl_s2_q.hit) begin
                rgb_d = palette_rgb(ctl_s2_q.piece_color);
            end else begin
                rgb_d = palette_rgb(board_data);
            end
        end else if (ctl_s2_q.border) begin
            rgb_d = BORDER_COLOR;
        end
    end

    // Sync delay lines reset high so no false sync pulse leaves after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_s1_q   <= 1'b0;
            border_s1_q  <= 1'b0;
            row_s1_q     <= '0;
            hs_pipe_q    <= '1;
            vs_pipe_q    <= '1;
            tick_pipe_q  <= '0;
            ctl_s2_q     <= '0;
            board_addr_q <= '0;
            rgb_q        <= BLANK_COLOR;
        end else begin
            ready_s1_q   <= ready_s1_d;
            border_s1_q  <= border_s1_d;
            row_s1_q     <= row_s1_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
            tick_pipe_q  <= tick_pipe_d;
            ctl_s2_q     <= ctl_s2_d;
            board_addr_q <= board_addr_d;
            rgb_q        <= rgb_d;
        end
    end

    assign board_addr = board_addr_q;
    assign rgb        = rgb_q;
    assign hsync_o    = hs_pipe_q[PIX_LAT-1];
    assign vsync_o    = vs_pipe_q[PIX_LAT-1];
    assign frame_tick = tick_pipe_q[PIX_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_tetris_board_render.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_board_render
// Summary  : Self-checking bench for tetris_board_render against a
//            geometric reference model of the playfield.
// Revision : 1.0
// ============================================================================
module tb_tetris_board_render;

    localparam int TX0 = 220;
    localparam int TY0 = 40;
    localparam int TCELL = 20;
    localparam int TW = 200;
    localparam int TH = 400;
    localparam int TB_BORDER = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] col_addr_sig = '0;
    logic [10:0] row_addr_sig = '0;
    logic        ready_sig = 1'b0;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic [7:0]  board_addr;
    logic [2:0]  board_data;
    logic [4:0]  piece_x = '0;
    logic [5:0]  piece_y = '0;
    logic [15:0] piece_mask = '0;
    logic [2:0]  piece_color = 3'd1;
    logic [7:0]  rgb;
    logic        hsync_o;
    logic        vsync_o;
    logic        frame_tick;

    logic [2:0]  ram [0:255];
    assign board_data = ram[board_addr];

    tetris_board_render dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .col_addr_sig (col_addr_sig),
        .row_addr_sig (row_addr_sig),
        .ready_sig    (ready_sig),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .board_addr   (board_addr),
        .board_data   (board_data),
        .piece_x      (piece_x),
        .piece_y      (piece_y),
        .piece_mask   (piece_mask),
        .piece_color  (piece_color),
        .rgb          (rgb),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         c;
        int         r;
        logic [7:0] rgb;
        bit         hs;
        bit         vs;
        bit         tick;
        bit         chk;
    } exp_t;

    typedef struct {
        int addr;
        bit chk;
    } addr_exp_t;

    exp_t        exp_q[$];
    addr_exp_t   addr_q[$];
    logic [7:0]  obs [int];
    bit          chk_en = 1'b0;
    bit          prev_rdy = 1'b0;
    int          prev_row = 0;
    int          addr_hold = 0;
    bit          addr_known = 1'b0;
    int          tick_seen = 0;

    function automatic logic [7:0] pal(input int i);
        case (i)
            0: return 8'h00;
            1: return 8'h1F;
            2: return 8'hFC;
            3: return 8'h83;
            4: return 8'h1C;
            5: return 8'hE0;
            6: return 8'h03;
            default: return 8'hF0;
        endcase
    endfunction

    function automatic bit in_brd(input int c, input int r);
        return (c >= TX0) && (c < TX0 + TW) && (r >= TY0) && (r < TY0 + TH);
    endfunction

    function automatic logic [7:0] model_rgb(input int c, input int r, input bit rdy);
        int cx, cy, dx, dy, sx, sy;
        if (!rdy) return 8'h00;
        if (in_brd(c, r)) begin
            if (((c - TX0) % TCELL == 0) || ((r - TY0) % TCELL == 0)) return 8'h49;
            cx = (c - TX0) / TCELL;
            cy = (r - TY0) / TCELL;
            sx = $signed(piece_x);
            sy = $signed(piece_y);
            dx = cx - sx;
            dy = cy - sy;
            if (dx >= 0 && dx <= 3 && dy >= 0 && dy <= 3 && piece_mask[dy*4 + dx])
                return pal(int'(piece_color));
            return pal(int'(ram[cy*10 + cx]));
        end
        if (c >= TX0 - TB_BORDER && c < TX0 + TW + TB_BORDER &&
            r >= TY0 - TB_BORDER && r < TY0 + TH + TB_BORDER) return 8'hFF;
        return 8'h00;
    endfunction

    // One pixel clock: drive inputs, then compare whatever has reached the outputs.
    task automatic step(input int c, input int r, input bit rdy, input bit hs, input bit vs);
        exp_t      e;
        addr_exp_t a;
        @(negedge clk);
        col_addr_sig = 11'(c);
        row_addr_sig = 11'(r);
        ready_sig    = rdy;
        hsync_i      = hs;
        vsync_i      = vs;
        e.c = c; e.r = r; e.hs = hs; e.vs = vs; e.chk = chk_en;
        e.rgb  = model_rgb(c, r, rdy);
        e.tick = prev_rdy && !rdy && (prev_row == 479);
        prev_rdy = rdy;
        prev_row = r;
        if (rdy && in_brd(c, r)) begin
            addr_hold = ((r - TY0) / TCELL) * 10 + (c - TX0) / TCELL;
            if (chk_en) addr_known = 1'b1;
        end
        a.addr = addr_hold;
        a.chk  = chk_en && addr_known;
        exp_q.push_back(e);
        addr_q.push_back(a);
        @(posedge clk);
        #1;
        if (frame_tick === 1'b1) tick_seen++;
        if (addr_q.size() >= 2) begin
            a = addr_q.pop_front();
            if (a.chk) begin
                checks++;
                if (board_addr !== 8'(a.addr)) begin
                    errors++;
                    $display("FAIL board_addr got=%0d exp=%0d", board_addr, a.addr);
                end
            end
        end
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            checks++;
            if (hsync_o !== e.hs || vsync_o !== e.vs) begin
                errors++;
                $display("FAIL sync col=%0d row=%0d got=%b%b exp=%b%b",
                         e.c, e.r, hsync_o, vsync_o, e.hs, e.vs);
            end
            if (e.chk) begin
                obs[e.r * 1024 + e.c] = rgb;
                checks++;
                if (rgb !== e.rgb) begin
                    errors++;
                    $display("FAIL rgb col=%0d row=%0d got=%02h exp=%02h", e.c, e.r, rgb, e.rgb);
                end
                checks++;
                if (frame_tick !== e.tick) begin
                    errors++;
                    $display("FAIL frame_tick col=%0d row=%0d got=%b exp=%b",
                             e.c, e.r, frame_tick, e.tick);
                end
            end
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        addr_q.delete();
        prev_rdy   = 1'b0;
        prev_row   = 0;
        addr_hold  = 0;
        addr_known = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (rgb !== 8'h00 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL %s rgb/tick got=%02h/%b exp=00/0", tag, rgb, frame_tick);
        end
        checks++;
        if (hsync_o !== 1'b1 || vsync_o !== 1'b1 || board_addr !== 8'd0) begin
            errors++;
            $display("FAIL %s sync/addr got=%b%b/%0d exp=11/0", tag, hsync_o, vsync_o, board_addr);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        chk_en = 1'b0;
        flush_model();
        #1;
        check_reset_values("midline_reset");
        @(negedge clk);
        check_reset_values("midline_reset_hold");
        rst_n = 1'b1;
    endtask

    task automatic check_obs(input string tag, input int c, input int r, input logic [7:0] expv);
        checks++;
        if (!obs.exists(r * 1024 + c)) begin
            errors++;
            $display("FAIL %s pixel (%0d,%0d) not observed exp=%02h", tag, c, r, expv);
        end else if (obs[r * 1024 + c] !== expv) begin
            errors++;
            $display("FAIL %s pixel (%0d,%0d) got=%02h exp=%02h", tag, c, r, obs[r * 1024 + c], expv);
        end
    endtask

    // Rows flagged in 'full' are scanned across the whole board; others get one active pixel.
    task automatic scan_frame(input bit [479:0] full, input int rst_row);
        bit was_chk;
        was_chk   = chk_en;
        tick_seen = 0;
        obs.delete();
        for (int r = 0; r < 480; r++) begin
            if (full[r]) begin
                int a, b;
                a = 200 + int'($urandom_range(0, 20));
                b = 420 + int'($urandom_range(0, 20));
                for (int c = a; c <= b; c++) begin
                    if (r == rst_row && c == 300) mid_reset();
                    step(c, r, 1'b1, 1'b1, 1'b1);
                end
                repeat (3) step(0, r, 1'b0, 1'b0, 1'b1);
            end else begin
                step(0, r, 1'b1, 1'b1, 1'b1);
                step(0, r, 1'b0, 1'b0, 1'b1);
            end
        end
        repeat (5) step(0, 0, 1'b0, 1'b1, 1'b0);
        if (was_chk && chk_en) begin
            checks++;
            if (tick_seen != 1) begin
                errors++;
                $display("FAIL frame_tick_count got=%0d exp=1", tick_seen);
            end
        end
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 256; i++) ram[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        chk_en = 1'b0;
        repeat (8) begin
            @(negedge clk);
            col_addr_sig = 11'($urandom_range(0, 639));
            row_addr_sig = 11'($urandom_range(0, 479));
            ready_sig    = 1'($urandom_range(0, 1));
            hsync_i      = 1'($urandom_range(0, 1));
            vsync_i      = 1'($urandom_range(0, 1));
            piece_mask   = 16'($urandom);
            @(posedge clk);
            #1;
            check_reset_values("reset");
        end
        @(negedge clk);
        ready_sig = 1'b0;
        hsync_i   = 1'b1;
        vsync_i   = 1'b1;
        rst_n     = 1'b1;
        flush_model();
        chk_en = 1'b1;
    endtask

    task automatic test_latency_border();
        step(216, 100, 1'b1, 1'b0, 1'b1);
        step(0, 100, 1'b0, 1'b1, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin
            errors++;
            $display("FAIL latency_early rgb got=%02h exp=00", rgb);
        end
        step(0, 100, 1'b0, 1'b1, 1'b1);
        checks++;
        if (rgb !== 8'hFF) begin
            errors++;
            $display("FAIL latency_border rgb got=%02h exp=ff", rgb);
        end
        checks++;
        if (hsync_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_hsync got=%b exp=0", hsync_o);
        end
        repeat (3) step(0, 100, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_addressing();
        bit [479:0] full;
        fill_ram();
        piece_mask = 16'h0000;
        full = '0;
        full[61] = 1'b1;
        scan_frame(full, -1);
        checks++;
        if (board_addr !== 8'd19) begin
            errors++;
            $display("FAIL addr_hold got=%0d exp=19", board_addr);
        end
    endtask

    task automatic test_board_colour();
        bit [479:0] full;
        fill_ram();
        ram[25]    = 3'd3;
        piece_mask = 16'h0000;
        full = '0;
        full[85] = 1'b1;
        scan_frame(full, -1);
        check_obs("board_colour", 325, 85, 8'h83);
        check_obs("board_grid", 320, 85, 8'h49);
    endtask

    task automatic test_piece_overlay();
        bit [479:0] full;
        fill_ram();
        ram[0]      = 3'd2;
        piece_x     = 5'h1F;
        piece_y     = 6'd0;
        piece_mask  = 16'h0002;
        piece_color = 3'd5;
        full = '0;
        full[50] = 1'b1;
        scan_frame(full, -1);
        check_obs("piece_hit", 230, 50, 8'hE0);
        piece_mask = 16'h0001;
        scan_frame(full, -1);
        check_obs("piece_miss", 230, 50, 8'hFC);
    endtask

    task automatic test_random_frames();
        bit [479:0] full;
        repeat (3) begin
            fill_ram();
            piece_x     = 5'(int'($urandom_range(0, 15)) - 3);
            piece_y     = 6'(int'($urandom_range(0, 22)) - 3);
            piece_mask  = 16'($urandom);
            piece_color = 3'($urandom_range(1, 7));
            full = '0;
            full[TY0] = 1'b1;
            repeat (8) full[$urandom_range(30, 449)] = 1'b1;
            scan_frame(full, -1);
        end
    endtask

    task automatic test_midline_reset();
        bit [479:0] full;
        fill_ram();
        piece_mask = 16'h0000;
        full = '0;
        full[200] = 1'b1;
        scan_frame(full, 200);
        chk_en = 1'b1;
        full = '0;
        full[40] = 1'b1;
        full[45] = 1'b1;
        full[200] = 1'b1;
        scan_frame(full, -1);
        check_obs("post_reset_grid", 230, 40, 8'h49);
        check_obs("post_reset_cell0", 225, 45, pal(int'(ram[0])));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 3'd0;
        test_reset();
        test_latency_border();
        test_addressing();
        test_board_colour();
        test_piece_overlay();
        test_random_frames();
        test_midline_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
